// File: rtl/wave_rom_scheduler_if.sv
// Bus between the waveform ROM scheduler and its voice/ROM/combiner environment.
// master drives ticks, voice state and ROM data; slave is the scheduler.
interface wave_rom_scheduler_if #(
    parameter int NUM_VOICES = 3,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8
);
    logic                         sample_tick;
    logic [NUM_VOICES-1:0]        voice_enables;
    logic [NUM_VOICES*ADDR_W-1:0] voice_addrs;
    logic                         rom_en;
    logic [ADDR_W-1:0]            rom_addr;
    logic [DATA_W-1:0]            rom_data;
    logic [NUM_VOICES*DATA_W-1:0] voice_samples;
    logic                         sample_valid;
    logic                         busy;
    logic                         overrun;
    logic                         overrun_clr;

    modport master (
        output sample_tick, voice_enables, voice_addrs, rom_data, overrun_clr,
        input  rom_en, rom_addr, voice_samples, sample_valid, busy, overrun
    );

    modport slave (
        input  sample_tick, voice_enables, voice_addrs, rom_data, overrun_clr,
        output rom_en, rom_addr, voice_samples, sample_valid, busy, overrun
    );
endinterface

// File: rtl/wave_rom_scheduler.sv
// Shares one synchronous waveform ROM among NUM_VOICES voices: one fetch round per
// sample_tick, all samples published together with a single sample_valid pulse.
module wave_rom_scheduler #(
    parameter int NUM_VOICES = 3,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int ROM_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    wave_rom_scheduler_if.slave  bus
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W = $clog2(ROM_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(ROM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                               state;
    logic [IDX_W-1:0]                     idx;
    logic [CNT_W-1:0]                     cnt;
    logic [NUM_VOICES-1:0]                snap_en;
    logic [NUM_VOICES-1:0][ADDR_W-1:0]    snap_addr;
    logic [NUM_VOICES-1:0][DATA_W-1:0]    shadow;
    logic                                 rom_en_q;
    logic [ADDR_W-1:0]                    rom_addr_q;
    logic [NUM_VOICES*DATA_W-1:0]         samples_q;
    logic                                 valid_q;
    logic                                 overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            snap_en    <= '0;
            snap_addr  <= '0;
            shadow     <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            samples_q  <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            valid_q    <= 1'b0;

            // A tick that cannot be served outranks a simultaneous clear.
            if (bus.sample_tick && state != IDLE)
                overrun_q <= 1'b1;
            else if (bus.overrun_clr)
                overrun_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.sample_tick) begin
                        snap_en   <= bus.voice_enables;
                        snap_addr <= bus.voice_addrs;
                        idx       <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (snap_en[idx]) begin
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= snap_addr[idx];
                        cnt        <= LAT_CNT;
                        state      <= WAIT;
                    end else begin
                        shadow[idx] <= '0;
                        if (idx == LAST_IDX) state <= DONE;
                        else                 idx   <= idx + 1'b1;
                    end
                end
                WAIT: begin
                    // cnt==1 marks the edge on which the ROM output belongs to this voice
                    if (cnt == CNT_ONE) begin
                        shadow[idx] <= bus.rom_data;
                        if (idx == LAST_IDX) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ISSUE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    samples_q <= shadow;
                    valid_q   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rom_en        = rom_en_q;
    assign bus.rom_addr      = rom_addr_q;
    assign bus.voice_samples = samples_q;
    assign bus.sample_valid  = valid_q;
    assign bus.busy          = (state != IDLE);
    assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_wave_rom_scheduler.sv
// Drives two schedulers (ROM_LAT 1 and 2) with identical voice stimulus and checks each
// against a per-voice timeline model derived from the round rules.
module tb_wave_rom_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        tick, clr;
    logic [2:0]  enables;
    logic [35:0] addrs;
    logic [7:0]  rd2;

    int vectors = 0;
    int miscompares = 0;

    wave_rom_scheduler_if #(.NUM_VOICES(3), .ADDR_W(12), .DATA_W(8)) b1();
    wave_rom_scheduler_if #(.NUM_VOICES(3), .ADDR_W(12), .DATA_W(8)) b2();

    wave_rom_scheduler #(.NUM_VOICES(3), .ADDR_W(12), .DATA_W(8), .ROM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .bus(b1.slave));
    wave_rom_scheduler #(.NUM_VOICES(3), .ADDR_W(12), .DATA_W(8), .ROM_LAT(2)) u2 (
        .clk(clk), .reset(reset), .bus(b2.slave));

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]};
    endfunction

    assign b1.sample_tick = tick;   assign b2.sample_tick = tick;
    assign b1.overrun_clr = clr;    assign b2.overrun_clr = clr;
    assign b1.voice_enables = enables; assign b2.voice_enables = enables;
    assign b1.voice_addrs = addrs;  assign b2.voice_addrs = addrs;

    // Latency-1 ROM: data for the strobed address is present on the next edge.
    assign b1.rom_data = b1.rom_en ? rom_f(b1.rom_addr) : 8'hEE;
    // Latency-2 ROM: one extra register stage.
    always @(posedge clk) rd2 <= b2.rom_en ? rom_f(b2.rom_addr) : 8'hEE;
    assign b2.rom_data = rd2;

    logic        o_en   [2];
    logic [11:0] o_addr [2];
    logic        o_sv   [2];
    logic        o_busy [2];
    logic        o_ovr  [2];
    logic [23:0] o_samp [2];
    assign o_en[0] = b1.rom_en;         assign o_en[1] = b2.rom_en;
    assign o_addr[0] = b1.rom_addr;     assign o_addr[1] = b2.rom_addr;
    assign o_sv[0] = b1.sample_valid;   assign o_sv[1] = b2.sample_valid;
    assign o_busy[0] = b1.busy;         assign o_busy[1] = b2.busy;
    assign o_ovr[0] = b1.overrun;       assign o_ovr[1] = b2.overrun;
    assign o_samp[0] = b1.voice_samples; assign o_samp[1] = b2.voice_samples;

    // Reference timeline per DUT, indexed by edge number after the tick edge.
    logic        exp_en   [2][0:31];
    logic [11:0] exp_addr [2][0:31];
    int          exp_v    [2];
    logic [23:0] exp_samp [2];
    logic [23:0] prev_samp[2];
    logic        exp_ovr  [2];

    task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d t=%0t obs=%0h exp=%0h", tag, d, $time, obs, exp);
        end
    endtask

    task automatic plan(input int d, input int lat, input logic [2:0] en, input logic [35:0] ad);
        int t;
        t = 0;
        for (int k = 0; k < 32; k++) begin
            exp_en[d][k] = 1'b0;
            exp_addr[d][k] = 12'h000;
        end
        exp_samp[d] = 24'h0;
        for (int v = 0; v < 3; v++) begin
            if (en[v]) begin
                t = t + 1;
                exp_en[d][t] = 1'b1;
                exp_addr[d][t] = ad[v*12 +: 12];
                exp_samp[d][v*8 +: 8] = rom_f(ad[v*12 +: 12]);
                t = t + lat;
            end else begin
                t = t + 1;
            end
        end
        exp_v[d] = t + 1;
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_rom_en"}, d, 64'(o_en[d]), 64'(0));
            chk({tag, "_rom_addr"}, d, 64'(o_addr[d]), 64'(0));
            chk({tag, "_valid"}, d, 64'(o_sv[d]), 64'(0));
            chk({tag, "_busy"}, d, 64'(o_busy[d]), 64'(0));
            chk({tag, "_samples"}, d, 64'(o_samp[d]), 64'(prev_samp[d]));
            chk({tag, "_overrun"}, d, 64'(o_ovr[d]), 64'(exp_ovr[d]));
        end
    endtask

    // One fetch round; optional mid-round input change and extra tick (+clear) at edge xk.
    task automatic run_round(input logic [2:0] en, input logic [35:0] ad,
                             input bit mid_change, input int xk, input bit xclr);
        int vmax;
        plan(0, 1, en, ad);
        plan(1, 2, en, ad);
        vmax = (exp_v[0] > exp_v[1]) ? exp_v[0] : exp_v[1];
        @(negedge clk);
        enables = en; addrs = ad; tick = 1'b1; clr = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= vmax; k++) begin
            @(negedge clk);
            tick = (k == xk);
            clr  = (k == xk) ? xclr : 1'b0;
            if (mid_change && k == 2) begin
                enables = 3'($urandom);
                addrs = {4'($urandom), $urandom};
            end
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                if (k == xk) begin
                    if (k <= exp_v[d]) exp_ovr[d] = 1'b1;
                    else if (xclr)     exp_ovr[d] = 1'b0;
                end
                chk("rom_en", d, 64'(o_en[d]), 64'(exp_en[d][k]));
                chk("rom_addr", d, 64'(o_addr[d]), 64'(exp_addr[d][k]));
                chk("sample_valid", d, 64'(o_sv[d]), 64'(k == exp_v[d]));
                chk("busy", d, 64'(o_busy[d]), 64'(k < exp_v[d]));
                chk("voice_samples", d, 64'(o_samp[d]), 64'((k >= exp_v[d]) ? exp_samp[d] : prev_samp[d]));
                chk("overrun", d, 64'(o_ovr[d]), 64'(exp_ovr[d]));
            end
        end
        @(negedge clk);
        tick = 1'b0; clr = 1'b0;
        for (int d = 0; d < 2; d++) prev_samp[d] = exp_samp[d];
    endtask

    task automatic clr_only();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        exp_ovr[0] = 1'b0; exp_ovr[1] = 1'b0;
        check_idle("clr");
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tick = 1'b0; clr = 1'b0; enables = 3'b000; addrs = 36'h0;
        prev_samp[0] = 24'h0; prev_samp[1] = 24'h0;
        exp_ovr[0] = 1'b0; exp_ovr[1] = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // three enabled voices, then a single voice, then silence
        run_round(3'b111, {12'h030, 12'h020, 12'h010}, 1'b0, 0, 1'b0);
        run_round(3'b010, {12'h000, 12'h0AB, 12'h000}, 1'b0, 0, 1'b0);
        run_round(3'b000, {12'h5A5, 12'hC3C, 12'h777}, 1'b0, 0, 1'b0);

        // overrun set, survives a same-cycle clear, then cleared alone
        run_round(3'b101, {12'h123, 12'h456, 12'h789}, 1'b0, 3, 1'b0);
        run_round(3'b111, {12'hFED, 12'h0CB, 12'hA98}, 1'b0, 2, 1'b1);
        clr_only();

        // snapshot isolation against mid-round input changes
        run_round(3'b111, {12'h9F1, 12'h2E3, 12'h4D5}, 1'b1, 0, 1'b0);

        // reset in the middle of a round
        @(negedge clk);
        enables = 3'b111; addrs = {12'h111, 12'h222, 12'h333}; tick = 1'b1;
        @(posedge clk);
        @(negedge clk); tick = 1'b0;
        @(posedge clk);
        @(negedge clk); reset = 1'b1;
        #1;
        prev_samp[0] = 24'h0; prev_samp[1] = 24'h0;
        exp_ovr[0] = 1'b0; exp_ovr[1] = 1'b0;
        check_idle("midreset");
        @(posedge clk); #1;
        check_idle("resethold");
        @(negedge clk); reset = 1'b0;
        run_round(3'b111, {12'h0F0, 12'h0E0, 12'h0D0}, 1'b0, 0, 1'b0);

        // randomized rounds, some back-to-back, some with idle gaps or overruns
        for (int r = 0; r < 30; r++) begin
            logic [2:0]  ren;
            logic [35:0] rad;
            int          xk, gap;
            ren = 3'($urandom);
            rad = {4'($urandom), $urandom};
            xk  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 0;
            run_round(ren, rad, 1'($urandom), xk, 1'($urandom));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                check_idle("gap");
                @(negedge clk);
            end
            if ($urandom_range(0, 3) == 0) clr_only();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
